lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
- Load/store sequencer sitting directly downstream of the main decoder.
- Consumes the decoder's memwrite/memtoreg/half/b/lbu controls plus the ALU address and store data.
- Runs a req/ready handshake with data memory, which may have variable latency.
- Returns a size-extended load result; stalls the core while an access is in flight; flags misaligned accesses and timeouts.

Parameters:
- TIMEOUT, 16: max cycles mem_req may stay high without mem_ready before aborting with err; must be ≥2.
- CW, 5: width of the timeout counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  memory instruction in the current cycle (memtoreg|memwrite)
- memwrite  in  1  1 = store, 0 = load
- half  in  1  decoder size bit
- b  in  1  decoder byte bit
- lbu  in  1  decoder unsigned-byte bit
- addr  in  32  byte address from the ALU
- wdata  in  32  store data (rt)
- mem_req  out  1  memory request valid
- mem_we  out  1  write enable accompanying mem_req
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- mem_wdata  out  32  store data replicated onto byte lanes
- mem_be  out  4  byte enables
- mem_ready  in  1  memory accepts/completes the request this cycle
- mem_rdata  in  32  read word, valid when mem_ready=1
- rdata  out  32  extended load result, held until next load completes
- done  out  1  one-cycle completion pulse
- stall  out  1  freeze PC/pipeline
- err  out  1  one-cycle pulse, misaligned or timeout (coincident with done)

Behaviour:
- Size decode, priority order:
  - lbu=1: byte, zero-extend.
  - half&b: byte, sign-extend.
  - half&~b: halfword, sign-extend.
  - else: word.
- Stores use the same decode; extension is ignored for stores.
- Little-endian; lane = addr[1:0].
- mem_be:
  - byte: 4'b0001<<addr[1:0].
  - half: 4'b0011<<{addr[1],1'b0}.
  - word: 4'b1111.
  - Loads drive mem_be with the same value.
- mem_wdata:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
- States: IDLE, BUSY, DONE, ERR.
- Registered outputs: mem_req, mem_we, mem_addr, mem_wdata, mem_be, rdata, done, err; all latched at start.
- IDLE:
  - start=1 and aligned: latch addr/size/we/wdata → BUSY.
  - start=1 and misaligned: → ERR; no memory access.
  - start=0: stay.
  - stall = start (combinational) in IDLE.
- BUSY:
  - mem_req=1; mem_req and all payload held stable until mem_ready.
  - Timeout counter clears on entry and increments each BUSY cycle with mem_ready=0.
  - On mem_ready=1: for a load, capture the extracted lane into rdata; → DONE.
  - On counter reaching TIMEOUT-1 with mem_ready=0: → ERR; mem_req drops next cycle.
  - stall=1.
- DONE: done=1, stall=0, mem_req=0; → IDLE.
- ERR: done=1, err=1, stall=0, mem_req=0, rdata unchanged; → IDLE.
- Latency: start in cycle 0 → mem_req in cycle 1. mem_ready in cycle 1 → done in cycle 2. Minimum 2 cycles; stall high in cycles 0–1.
- start in BUSY/DONE/ERR: ignored. The core is stalled in BUSY; in DONE/ERR the core is responsible for not re-issuing in the same cycle.
- mem_ready outside BUSY: ignored.
- Stores never modify rdata.
- Reset, asynchronous, active-low:
  - state=IDLE.
  - mem_req/mem_we/done/err = 0; mem_be = 0.
  - mem_addr/mem_wdata/rdata = 0; counter = 0.
- Reset asserted mid-BUSY drops mem_req immediately without waiting for a clock edge; the in-flight access is abandoned.

Decomposition:
- Shared package mips_pkg:
  - enum lsu_state_t {IDLE,BUSY,DONE,ERR}.
  - enum mem_size_t {SZ_BYTE,SZ_HALF,SZ_WORD}.
  - Function decode_size(half,b,lbu) returning size + unsigned flag.
- One combinational sub-module, lsu_lane: byte-enable/replication generation plus load lane extraction/extension. Reused by a future store-byte/halfword path.

Test Plan:
- LW, addr=0x0000_0010, mem_ready in 1st BUSY cycle, mem_rdata=0xDEADBEEF → mem_be=1111, mem_addr=0x10, done in cycle 2, rdata=0xDEADBEEF, stall high cycles 0–1.
- LB (half=1,b=1) addr=0x13, mem_rdata=0x80AA55CC, ready after 3 wait cycles → mem_be=1000, payload stable for 4 cycles, rdata=0xFFFFFF80.
- LBU (lbu=1) addr=0x13, same data → rdata=0x00000080. LH addr=0x12 → rdata=0xFFFF80AA.
- SW addr=0x20, wdata=0x12345678 → mem_we=1, mem_be=1111, mem_wdata=0x12345678; rdata unchanged; done once.
- LH addr=0x11 → no mem_req; done=err=1 in cycle 1. LW addr=0x22 → same.
- LW with mem_ready held 0 → mem_req high exactly TIMEOUT cycles, then done=err=1. Separate run: reset low mid-BUSY → mem_req=0 asynchronously, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and size-decode helpers for the load/store path
package mips_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} lsu_state_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_t;

  typedef struct packed {
    mem_size_t size;
    logic      uns;
  } size_dec_t;

  // lbu wins over half/b; half&b is a signed byte, half alone a signed halfword
  function automatic size_dec_t decode_size(input logic half, input logic b, input logic lbu);
    size_dec_t d;
    if (lbu) begin
      d.size = SZ_BYTE;
      d.uns  = 1'b1;
    end else if (half && b) begin
      d.size = SZ_BYTE;
      d.uns  = 1'b0;
    end else if (half) begin
      d.size = SZ_HALF;
      d.uns  = 1'b0;
    end else begin
      d.size = SZ_WORD;
      d.uns  = 1'b0;
    end
    return d;
  endfunction

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lane);
    logic m;
    case (size)
      SZ_HALF: m = lane[0];
      SZ_WORD: m = (lane != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - byte-enable/store replication and load lane extraction
module lsu_lane
  import mips_pkg::*;
(
  input  mem_size_t   i_size,
  input  logic        i_uns,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte enables and store data replicated across all lanes of the access size
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_lane;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_be    = 4'b0011 << {i_lane[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  // Pick the addressed lane out of the little-endian read word and extend it
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_lane)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      SZ_BYTE: o_rdata = i_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: o_rdata = {{16{w_half[15]}}, w_half};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer with memory handshake, stall, misalign and timeout
module lsu_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        memwrite,
  input  logic        half,
  input  logic        b,
  input  logic        lbu,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        stall,
  output logic        err
);

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_t  r_state;
  mem_size_t   r_size;
  logic        r_uns;
  logic [1:0]  r_lane;
  logic [CW-1:0] r_cnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_done;
  logic        r_err;

  size_dec_t   w_dec;
  logic        w_misal;
  mem_size_t   w_size_sel;
  logic        w_uns_sel;
  logic [1:0]  w_lane_sel;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rext;

  assign w_dec   = decode_size(half, b, lbu);
  assign w_misal = is_misaligned(w_dec.size, addr[1:0]);

  // The lane helper builds the request from live inputs in IDLE and extracts
  // the load result from the latched size/lane while the access is in flight
  assign w_size_sel = (r_state == IDLE) ? w_dec.size : r_size;
  assign w_uns_sel  = (r_state == IDLE) ? w_dec.uns  : r_uns;
  assign w_lane_sel = (r_state == IDLE) ? addr[1:0]  : r_lane;

  lsu_lane u_lane (
    .i_size  (w_size_sel),
    .i_uns   (w_uns_sel),
    .i_lane  (w_lane_sel),
    .i_wdata (wdata),
    .i_rdata (mem_rdata),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_rdata (w_rext)
  );

  // Stall covers the issuing cycle and every cycle the access is outstanding
  always_comb begin
    case (r_state)
      IDLE:    stall = start;
      BUSY:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // Sequencer: latch at start, hold the request until ready or timeout, pulse done/err
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_size  <= SZ_WORD;
      r_uns   <= 1'b0;
      r_lane  <= 2'b00;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_be    <= 4'h0;
      r_rdata <= 32'h0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (start) begin
            if (w_misal) begin
              r_state <= ERR;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state <= BUSY;
              r_req   <= 1'b1;
              r_we    <= memwrite;
              r_addr  <= {addr[31:2], 2'b00};
              r_wdata <= w_wdata;
              r_be    <= w_be;
              r_size  <= w_dec.size;
              r_uns   <= w_dec.uns;
              r_lane  <= addr[1:0];
              r_cnt   <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (!r_we) r_rdata <= w_rext;
            r_req   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_req   <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= ERR;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_be    = r_be;
  assign rdata     = r_rdata;
  assign done      = r_done;
  assign err       = r_err;

endmodule
